// File: rtl/regfile_writeback_if.sv
// Result/write/bypass bus of the register-file write-back block.
// The master modport is taken by regfile_writeback; slave is the execute/register-file side.
interface regfile_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ResValid;
  logic              ResReady;
  logic [ADDR_W-1:0] ResAddr;
  logic [DATA_W-1:0] ResData;
  logic              Stall;
  logic              Write;
  logic [ADDR_W-1:0] DestAddr;
  logic [DATA_W-1:0] DestData;
  logic [ADDR_W-1:0] AddrA;
  logic [ADDR_W-1:0] AddrB;
  logic              HitA;
  logic [DATA_W-1:0] FwdA;
  logic              HitB;
  logic [DATA_W-1:0] FwdB;
  logic [CNT_W-1:0]  Count;
  logic              Empty;

  modport master (
    input  ResValid, ResAddr, ResData, Stall, AddrA, AddrB,
    output ResReady, Write, DestAddr, DestData, HitA, FwdA, HitB, FwdB, Count, Empty
  );

  modport slave (
    output ResValid, ResAddr, ResData, Stall, AddrA, AddrB,
    input  ResReady, Write, DestAddr, DestData, HitA, FwdA, HitB, FwdB, Count, Empty
  );
endinterface

// File: rtl/regfile_writeback.sv
// In-order result queue driving the register-file write port, with read-after-write bypass.
// Optional macro WB_BYPASS_EN builds the HitA/FwdA/HitB/FwdB forwarding logic; otherwise they are tied to 0.
module regfile_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
  logic [DATA_W-1:0] dest_data_q, dest_data_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic              push, pop;

  always_comb begin
    // Full check uses the current count only, so a full queue never accepts even while draining.
    push        = bus.ResValid && (count_q != CNT_W'(DEPTH));
    pop         = (count_q != '0) && !bus.Stall;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    write_d     = pop;
    dest_addr_d = dest_addr_q;
    dest_data_d = dest_data_q;
    if (pop) begin
      dest_addr_d = addr_mem_q[rd_ptr_q];
      dest_data_d = data_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      write_q     <= 1'b0;
      dest_addr_q <= '0;
      dest_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      write_q     <= write_d;
      dest_addr_q <= dest_addr_d;
      dest_data_q <= dest_data_d;
    end
  end

  // Queue storage needs no reset: entries are only visible through the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.ResAddr;
      data_mem_q[wr_ptr_q] <= bus.ResData;
    end
  end

  assign bus.ResReady = (count_q != CNT_W'(DEPTH));
  assign bus.Write    = write_q;
  assign bus.DestAddr = dest_addr_q;
  assign bus.DestData = dest_data_q;
  assign bus.Count    = count_q;
  assign bus.Empty    = (count_q == '0) && !write_q;

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest (output register, then head..tail) so the last match wins.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (write_q && (dest_addr_q == addr)) res = {1'b1, dest_data_q};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem_q[idx] == addr)) res = {1'b1, data_mem_q[idx]};
    end
    return res;
  endfunction

  assign {bus.HitA, bus.FwdA} = fwd_lookup(bus.AddrA);
  assign {bus.HitB, bus.FwdB} = fwd_lookup(bus.AddrB);
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{bus.AddrA, bus.AddrB};
  assign bus.HitA = 1'b0;
  assign bus.FwdA = '0;
  assign bus.HitB = 1'b0;
  assign bus.FwdB = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue scoreboard checked every cycle, plus table and directed sequences.
module tb_regfile_writeback;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus();

  regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  typedef struct {
    logic              vld;
    logic              stall;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                e_count;
    logic              e_ready;
    logic              e_write;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  ent_t mq[$];
  ent_t mout;
  logic mwrite;
  bit   started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W:0] mfwd(input logic [ADDR_W-1:0] a);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (mwrite && (mout.a == a)) return {1'b1, mout.d};
    return '0;
  endfunction

  // Reference queue: accepted results pushed at the accepting edge, popped into the output register.
  always @(posedge clk) begin : model
    logic acc;
    if (reset) begin
      mq.delete();
      mwrite  = 1'b0;
      mout    = '0;
      started = 1;
    end else begin
      acc = bus.ResValid && (mq.size() < DEPTH);
      if ((mq.size() != 0) && !bus.Stall) begin
        mout   = mq.pop_front();
        mwrite = 1'b1;
      end else begin
        mwrite = 1'b0;
      end
      if (acc) mq.push_back('{bus.ResAddr, bus.ResData});
    end
  end

  always @(negedge clk) begin : monitor
    logic [DATA_W:0] ea, eb;
    if (started) begin
      chk("write", bus.Write, mwrite);
      chk("count", bus.Count, mq.size());
      chk("ready", bus.ResReady, mq.size() < DEPTH);
      chk("empty", bus.Empty, (mq.size() == 0) && !mwrite);
      chk("dest_addr", bus.DestAddr, mout.a);
      chk("dest_data", bus.DestData, mout.d);
`ifdef WB_BYPASS_EN
      ea = mfwd(bus.AddrA);
      eb = mfwd(bus.AddrB);
`else
      ea = '0;
      eb = '0;
`endif
      chk("bypass_a", {bus.HitA, bus.FwdA}, ea);
      chk("bypass_b", {bus.HitB, bus.FwdB}, eb);
      if (bus.Write === 1'b1) writes++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic stall, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bus.ResValid = vld;
    bus.Stall    = stall;
    bus.ResAddr  = a;
    bus.ResData  = d;
  endtask

  initial begin
    vec_t tbl[11];
    int   w0;

    tbl[0]  = '{1'b1, 1'b1, 2'd0, 16'h0001, 0, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 2'd1, 16'h0002, 1, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 2'd2, 16'h0003, 2, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 2'd3, 16'h0004, 3, 1'b1, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b1, 2'd0, 16'h0099, 4, 1'b0, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4, 1'b0, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 3, 1'b1, 1'b1, 16'h0001};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 2, 1'b1, 1'b1, 16'h0002};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1, 1'b1, 1'b1, 16'h0003};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 0, 1'b1, 1'b1, 16'h0004};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};

    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    bus.AddrA = '0;
    bus.AddrB = '0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write", bus.Write, 0);
    chk("rst_count", bus.Count, 0);
    chk("rst_empty", bus.Empty, 1);
    chk("rst_ready", bus.ResReady, 1);
    chk("rst_dest", {bus.DestAddr, bus.DestData}, 0);
    tick();
    reset = 1'b0;

    // Single result, one-cycle latency to Write
    drive(1'b1, 1'b0, 2'd2, 16'h00A5);
    @(negedge clk);
    chk("single_pre_write", bus.Write, 0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("single_e0_write", bus.Write, 0);
    chk("single_e0_count", bus.Count, 1);
    tick();
    @(negedge clk);
    chk("single_e1_write", bus.Write, 1);
    chk("single_e1_addr", bus.DestAddr, 2);
    chk("single_e1_data", bus.DestData, 16'h00A5);
    chk("single_e1_count", bus.Count, 0);
    tick();
    @(negedge clk);
    chk("single_e2_write", bus.Write, 0);
    chk("single_e2_empty", bus.Empty, 1);
    tick();

    // Fill under stall, reject fifth, drain in order
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].vld, tbl[k].stall, tbl[k].a, tbl[k].d);
      @(negedge clk);
      chk($sformatf("tbl%0d_count", k), bus.Count, tbl[k].e_count);
      chk($sformatf("tbl%0d_ready", k), bus.ResReady, tbl[k].e_ready);
      chk($sformatf("tbl%0d_write", k), bus.Write, tbl[k].e_write);
      if (tbl[k].e_write) chk($sformatf("tbl%0d_data", k), bus.DestData, tbl[k].e_data);
      tick();
    end

    // Bypass: two pending writes to R1, youngest wins
    bus.AddrA = 2'd1;
    bus.AddrB = 2'd3;
    drive(1'b1, 1'b1, 2'd1, 16'h1111);
    tick();
    drive(1'b1, 1'b1, 2'd1, 16'h2222);
    tick();
    drive(1'b0, 1'b1, '0, '0);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("byp_hitA", bus.HitA, 1);
    chk("byp_fwdA", bus.FwdA, 16'h2222);
`else
    chk("byp_hitA", bus.HitA, 0);
    chk("byp_fwdA", bus.FwdA, 0);
`endif
    chk("byp_hitB", bus.HitB, 0);
    chk("byp_fwdB", bus.FwdB, 0);
    tick();
    bus.AddrB = 2'd1;
    @(negedge clk);
    chk("byp_same_addr", {bus.HitB, bus.FwdB}, {bus.HitA, bus.FwdA});
    tick();
    drive(1'b0, 1'b0, '0, '0);
    repeat (4) tick();

    // Streaming 16 results with no stall
    w0 = writes;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, ADDR_W'(i), DATA_W'(16'h0100 + i));
      bus.AddrA = ADDR_W'(i + 1);
      bus.AddrB = ADDR_W'(i + 2);
      @(negedge clk);
      chk("stream_count_le1", bus.Count <= 1, 1);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    repeat (4) tick();
    chk("stream_writes", writes - w0, 16);

    // Reset while three entries are queued under stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, ADDR_W'(i), DATA_W'(16'hBEE0 + i));
      tick();
    end
    drive(1'b0, 1'b1, '0, '0);
    @(negedge clk);
    chk("flush_pre_count", bus.Count, 3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("flush_count", bus.Count, 0);
    chk("flush_ready", bus.ResReady, 1);
    chk("flush_empty", bus.Empty, 1);
    w0 = writes;
    repeat (5) tick();
    chk("flush_no_writes", writes - w0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
